sram_loader: RTL and testbench
==============================

SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameter LOAD_WORDS, default 13504, number of 16-bit words written from address 0 upward.
REQ-002 Parameter WR_CYCLES, default 2, WE_n low width in clk cycles (1..15).
REQ-003 Parameter RD_CYCLES, default 2, OE_n low cycles before read data is sampled (1..15).
REQ-004 Parameter RESULT_ADDR, default 20'h34C0, theta result word; phi result word at RESULT_ADDR+1.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-low.
REQ-007 load_start  in  1  pulse; begins a LOAD_WORDS-word load from address 0.
REQ-008 in_data  in  16  stream word to write.
REQ-009 in_valid  in  1  in_data valid.
REQ-010 in_ready  out  1  loader accepts in_data this cycle.
REQ-011 addr  out  20  SRAM address.
REQ-012 CE_n, OE_n, WE_n, UB_n, LB_n  out  1 each  SRAM controls, active-low.
REQ-013 sram_data_out  out  16  write data to SRAM pad.
REQ-014 sram_data_oe  out  1  pad drive enable for sram_data_out.
REQ-015 sram_data_in  in  16  read data from SRAM pad.
REQ-016 start  out  1  level; high from load completion until next load_start or reset.
REQ-017 result_req  in  1  pulse; read back theta/phi result words.
REQ-018 result_valid  out  1  one-cycle pulse, results valid.
REQ-019 result_theta, result_phi  out  12 each  sram_data_in[11:0] of the two result words.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, ACCEPT, SETUP, WRITE, HOLD, DONE, RD_SETUP, RD_WAIT, RESULT.
REQ-022 IDLE: load_start -> ACCEPT with addr=0, start=0; else result_req -> RD_SETUP; load_start wins if both high.
REQ-023 ACCEPT: in_ready=1; in_valid -> latch in_data into sram_data_out, go SETUP; stay otherwise (no timeout).
REQ-024 SETUP (1 cycle): sram_data_oe=1, WE_n=1, OE_n=1, addr stable.
REQ-025 WRITE: WE_n=0 for exactly WR_CYCLES cycles; addr and sram_data_out unchanged.
REQ-026 HOLD (1 cycle): WE_n=1, sram_data_oe still 1; then if addr==LOAD_WORDS-1 -> DONE, else addr+1 -> ACCEPT.
REQ-027 Word cost: 2+WR_CYCLES cycles plus ACCEPT wait; throughput 1 word per 3+WR_CYCLES cycles with in_valid held high.
REQ-028 DONE (1 cycle): sram_data_oe=0, start=1, -> IDLE; addr holds last written address.
REQ-029 RD_SETUP: addr=RESULT_ADDR (then RESULT_ADDR+1 on second pass), OE_n=0, sram_data_oe=0.
REQ-030 RD_WAIT: OE_n=0 for RD_CYCLES cycles; sample sram_data_in[11:0] on last cycle into theta (pass 1) or phi (pass 2).
REQ-031 After phi sample -> RESULT: result_valid=1 for one cycle, -> IDLE; result_theta/phi hold until next read.
REQ-032 OE_n=1 whenever WE_n=0 or sram_data_oe=1; sram_data_oe=0 whenever OE_n=0 (no bus contention).
REQ-033 CE_n, UB_n, LB_n = 0 at all times after reset.
REQ-034 load_start and result_req ignored outside IDLE; in_valid ignored outside ACCEPT (in_ready=0).
REQ-035 addr arithmetic 20-bit unsigned; never exceeds LOAD_WORDS-1 during load, no wrap.

Reset
REQ-036 On rst=0 at clk edge: state=IDLE, addr=0, WE_n=1, OE_n=1, CE_n=UB_n=LB_n=0, sram_data_oe=0, sram_data_out=0, in_ready=0, start=0, result_valid=0, result_theta=result_phi=0, busy=0.
REQ-037 Reset mid-WRITE releases WE_n at the same edge; the partially written word is not retried.

Structure
REQ-038 Shared package sram_pkg holds ADDR_W=20, DATA_W=16, LOAD_WORDS, RESULT_ADDR, and the FSM state enum.
REQ-039 One sub-module sram_cycle_timer: 4-bit down-counter, load/expire, used for WR_CYCLES and RD_CYCLES.

Verification
REQ-040 Load 4 words (LOAD_WORDS=4) 16'hA001..A004, in_valid always high -> SRAM model holds them at 0..3, start rises 1 cycle after last HOLD, total 4*(3+WR_CYCLES)+2 cycles.
REQ-041 in_valid gapped 5 cycles between words -> in_ready stays high through gap, WE_n pulses exactly WR_CYCLES wide, no extra writes.
REQ-042 Model holds 16'h0123 at 0x34C0, 16'h0F45 at 0x34C1; result_req -> result_theta=12'h123, result_phi=12'hF45, single result_valid pulse.
REQ-043 load_start and result_req same cycle in IDLE -> load runs, result_req dropped, result_valid never asserts.
REQ-044 rst low during WRITE of word 2 -> WE_n=1 next edge, addr=0, start=0; new load_start rewrites from address 0.
REQ-045 Assertion every cycle: never (OE_n==0 and (WE_n==0 or sram_data_oe==1)).

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, load/result defaults and loader FSM states
package sram_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int unsigned LOAD_WORDS = 13504;
  localparam logic [ADDR_W-1:0] RESULT_ADDR = 20'h34C0;
  typedef enum logic [3:0] {
    IDLE, ACCEPT, SETUP, WRITE, HOLD, DONE, RD_SETUP, RD_WAIT, RESULT
  } state_t;
endpackage

// File: rtl/sram_cycle_timer.sv
// sram_cycle_timer: 4-bit down-counter timing WE_n/OE_n strobe widths
module sram_cycle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  output logic       expired
);
  logic [3:0] cnt;
  // Reload on demand, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else cnt <= load ? value : (cnt != 4'd0 ? cnt - 4'd1 : cnt);
  end
  assign expired = cnt == 4'd0;
endmodule

// File: rtl/sram_loader.sv
// sram_loader: streams words into an async SRAM and reads back theta/phi results
module sram_loader #(
  parameter int unsigned LOAD_WORDS  = sram_pkg::LOAD_WORDS,
  parameter int unsigned WR_CYCLES   = 2,
  parameter int unsigned RD_CYCLES   = 2,
  parameter logic [19:0] RESULT_ADDR = sram_pkg::RESULT_ADDR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic [sram_pkg::DATA_W-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [sram_pkg::ADDR_W-1:0] addr,
  output logic                        CE_n,
  output logic                        OE_n,
  output logic                        WE_n,
  output logic                        UB_n,
  output logic                        LB_n,
  output logic [sram_pkg::DATA_W-1:0] sram_data_out,
  output logic                        sram_data_oe,
  input  logic [sram_pkg::DATA_W-1:0] sram_data_in,
  output logic                        start,
  input  logic                        result_req,
  output logic                        result_valid,
  output logic [11:0]                 result_theta,
  output logic [11:0]                 result_phi,
  output logic                        busy
);
  import sram_pkg::*;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);
  state_t state, state_nx;
  logic pass, tmr_load, tmr_exp;
  logic [3:0] tmr_val;
  logic [3:0] unused_hi;
  assign unused_hi = sram_data_in[15:12];
  sram_cycle_timer u_tmr (
    .clk,
    .rst,
    .load(tmr_load),
    .value(tmr_val),
    .expired(tmr_exp)
  );
  // Next state; the strobe timer is armed on the cycle before WRITE/RD_WAIT
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = 4'(WR_CYCLES - 1);
    case (state)
      IDLE:     state_nx = load_start ? ACCEPT : (result_req ? RD_SETUP : IDLE);
      ACCEPT:   state_nx = in_valid ? SETUP : ACCEPT;
      SETUP:    begin state_nx = WRITE; tmr_load = 1'b1; end
      WRITE:    state_nx = tmr_exp ? HOLD : WRITE;
      HOLD:     state_nx = addr == LAST_ADDR ? DONE : ACCEPT;
      DONE:     state_nx = IDLE;
      RD_SETUP: begin state_nx = RD_WAIT; tmr_load = 1'b1; tmr_val = 4'(RD_CYCLES - 1); end
      RD_WAIT:  state_nx = tmr_exp ? (pass ? RESULT : RD_SETUP) : RD_WAIT;
      RESULT:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  // State register with address, write-data and result capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      addr          <= '0;
      sram_data_out <= '0;
      start         <= 1'b0;
      pass          <= 1'b0;
      result_theta  <= '0;
      result_phi    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (load_start) begin addr <= '0; start <= 1'b0; end
          else if (result_req) begin addr <= RESULT_ADDR; pass <= 1'b0; end
        end
        ACCEPT: if (in_valid) sram_data_out <= in_data;
        HOLD: if (addr == LAST_ADDR) start <= 1'b1; else addr <= addr + ADDR_W'(1);
        RD_WAIT: begin
          if (tmr_exp && pass) result_phi <= sram_data_in[11:0];
          else if (tmr_exp) begin
            result_theta <= sram_data_in[11:0];
            addr         <= RESULT_ADDR + ADDR_W'(1);
            pass         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign in_ready     = state == ACCEPT;
  assign WE_n         = state != WRITE;
  assign OE_n         = !(state == RD_SETUP || state == RD_WAIT);
  assign sram_data_oe = state inside {SETUP, WRITE, HOLD};
  assign result_valid = state == RESULT;
  assign busy         = state != IDLE;
  assign CE_n         = 1'b0;
  assign UB_n         = 1'b0;
  assign LB_n         = 1'b0;
endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: randomized self-checking bench against an SRAM + timing model
module tb_sram_loader;
  localparam int LW = 4;
  localparam int WR = 2;
  localparam int RD = 2;
  logic clk = 0, rst = 0, load_start = 0, in_valid = 0, result_req = 0;
  logic [15:0] in_data = 0;
  logic in_ready, CE_n, OE_n, WE_n, UB_n, LB_n, sram_data_oe, start, result_valid, busy;
  logic [19:0] addr;
  logic [15:0] sram_data_out, sram_data_in;
  logic [11:0] result_theta, result_phi;
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] mem [0:16383];
  typedef struct {logic [19:0] a; logic [15:0] d; int w;} wr_t;
  wr_t wq[$];
  int cur_w = 0, rv_cnt = 0, start_rise = -1, busy_fall = -1;
  logic [19:0] cur_a;
  logic [15:0] cur_d;
  logic prev_start = 0, prev_busy = 0, mon_en = 0;

  sram_loader #(.LOAD_WORDS(LW), .WR_CYCLES(WR), .RD_CYCLES(RD), .RESULT_ADDR(20'h34C0)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .addr(addr), .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .UB_n(UB_n),
    .LB_n(LB_n), .sram_data_out(sram_data_out), .sram_data_oe(sram_data_oe),
    .sram_data_in(sram_data_in), .start(start), .result_req(result_req),
    .result_valid(result_valid), .result_theta(result_theta), .result_phi(result_phi), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign sram_data_in = OE_n ? 16'h0000 : mem[addr[13:0]];

  // SRAM model and bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!WE_n) begin cur_w++; cur_a = addr; cur_d = sram_data_out; end
    else if (cur_w > 0) begin
      wq.push_back('{cur_a, cur_d, cur_w});
      mem[cur_a[13:0]] = cur_d;
      cur_w = 0;
    end
    if (result_valid) rv_cnt++;
    if (start && !prev_start) start_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    prev_start = start;
    prev_busy = busy;
    if (mon_en) begin
      total++;
      if (!OE_n && (!WE_n || sram_data_oe)) begin
        bad++; $display("FAIL contention OE_n=%b WE_n=%b oe=%b at cyc %0d", OE_n, WE_n, sram_data_oe, cyc);
      end
      total++;
      if ({CE_n, UB_n, LB_n} !== 3'b000) begin
        bad++; $display("FAIL ce_ub_lb got=%b want=000", {CE_n, UB_n, LB_n});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 0;
    in_valid = 1;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({WE_n, OE_n, CE_n, UB_n, LB_n, sram_data_oe, in_ready, start, result_valid, busy} !== 10'b1100000000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=1100000000",
        {WE_n, OE_n, CE_n, UB_n, LB_n, sram_data_oe, in_ready, start, result_valid, busy});
    end
    total++;
    if (addr !== 20'h0 || sram_data_out !== 16'h0) begin
      bad++; $display("FAIL reset_addr_data got addr=%h data=%h want 0/0", addr, sram_data_out);
    end
    total++;
    if (result_theta !== 12'h0 || result_phi !== 12'h0) begin
      bad++; $display("FAIL reset_results got theta=%h phi=%h want 0/0", result_theta, result_phi);
    end
    rst = 1;
    tick();
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_ignores_valid got in_ready=%b busy=%b want 0/0", in_ready, busy);
    end
    in_valid = 0;
    mon_en = 1;
  endtask

  task automatic do_load(input logic [15:0] w[$], input int gap, input bit req_too, output int c0);
    int n;
    bit acc, seen;
    wq.delete();
    start_rise = -1;
    busy_fall = -1;
    load_start = 1;
    result_req = req_too;
    tick();
    c0 = cyc;
    load_start = 0;
    for (int i = 0; i < w.size(); i++) begin
      if (gap > 0) begin
        in_valid = 0;
        seen = 0;
        repeat (gap) begin
          @(negedge clk);
          if (seen) begin
            total++;
            if (!in_ready) begin bad++; $display("FAIL gap_ready word%0d got in_ready=0 want 1", i); end
          end
          seen |= in_ready;
          tick();
        end
        total++;
        if (!seen) begin bad++; $display("FAIL gap_accept_reached word%0d got in_ready=0 want 1", i); end
      end
      in_valid = 1;
      in_data = w[i];
      acc = 0;
      n = 0;
      while (!acc && n < 100) begin
        @(negedge clk);
        acc = in_ready;
        tick();
        n++;
      end
      total++;
      if (!acc) begin bad++; $display("FAIL accept_timeout word%0d got in_ready=0 want 1", i); end
    end
    in_valid = 0;
    result_req = 0;
    n = 0;
    acc = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = !busy;
      n++;
    end
    total++;
    if (!acc) begin bad++; $display("FAIL load_done_timeout got busy=1 want 0"); end
    tick();
  endtask

  task automatic check_load(input logic [15:0] w[$], input int c0, input bit timing);
    total++;
    if (wq.size() != w.size()) begin
      bad++; $display("FAIL write_count got=%0d want=%0d", wq.size(), w.size());
    end
    for (int i = 0; i < w.size() && i < wq.size(); i++) begin
      total++;
      if (wq[i].a !== 20'(i) || wq[i].d !== w[i] || wq[i].w != WR) begin
        bad++; $display("FAIL write%0d got a=%h d=%h w=%0d want a=%h d=%h w=%0d",
          i, wq[i].a, wq[i].d, wq[i].w, 20'(i), w[i], WR);
      end
    end
    for (int i = 0; i < w.size(); i++) begin
      total++;
      if (mem[i] !== w[i]) begin bad++; $display("FAIL mem%0d got=%h want=%h", i, mem[i], w[i]); end
    end
    total++;
    if (start !== 1'b1 || busy !== 1'b0 || addr !== 20'(LW - 1)) begin
      bad++; $display("FAIL done_state got start=%b busy=%b addr=%h want 1/0/%h", start, busy, addr, 20'(LW - 1));
    end
    if (timing) begin
      total++;
      if (start_rise != c0 + LW * (3 + WR)) begin
        bad++; $display("FAIL start_rise got=%0d want=%0d", start_rise - c0, LW * (3 + WR));
      end
      total++;
      if (busy_fall != c0 + LW * (3 + WR) + 1) begin
        bad++; $display("FAIL load_cycles got=%0d want=%0d", busy_fall - c0 + 1, LW * (3 + WR) + 2);
      end
    end
  endtask

  task automatic test_stream(input bit fixed);
    logic [15:0] w[$];
    int c0;
    for (int i = 0; i < LW; i++) w.push_back(fixed ? 16'hA001 + 16'(i) : 16'($urandom));
    do_load(w, 0, 0, c0);
    check_load(w, c0, 1);
  endtask

  task automatic test_gapped();
    logic [15:0] w[$];
    int c0;
    for (int i = 0; i < LW; i++) w.push_back(16'($urandom));
    do_load(w, 5, 0, c0);
    check_load(w, c0, 0);
  endtask

  task automatic test_result(input logic [15:0] t, input logic [15:0] p);
    int c0, n, rv0;
    bit got;
    mem[14'h34C0] = t;
    mem[14'h34C1] = p;
    rv0 = rv_cnt;
    result_req = 1;
    tick();
    c0 = cyc;
    result_req = 0;
    got = 0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (result_valid) got = 1;
      else tick();
      n++;
    end
    total++;
    if (!got) begin bad++; $display("FAIL result_timeout got result_valid=0 want 1"); end
    total++;
    if (cyc != c0 + 2 * (1 + RD)) begin
      bad++; $display("FAIL result_latency got=%0d want=%0d", cyc - c0, 2 * (1 + RD));
    end
    total++;
    if (result_theta !== t[11:0] || result_phi !== p[11:0]) begin
      bad++; $display("FAIL result_values got theta=%h phi=%h want %h/%h", result_theta, result_phi, t[11:0], p[11:0]);
    end
    repeat (4) tick();
    total++;
    if (rv_cnt != rv0 + 1 || result_theta !== t[11:0] || result_phi !== p[11:0]) begin
      bad++; $display("FAIL result_pulse_hold got pulses=%0d theta=%h phi=%h want 1/%h/%h",
        rv_cnt - rv0, result_theta, result_phi, t[11:0], p[11:0]);
    end
  endtask

  task automatic test_collision();
    logic [15:0] w[$];
    int c0, rv0;
    for (int i = 0; i < LW; i++) w.push_back(16'($urandom));
    rv0 = rv_cnt;
    do_load(w, 0, 1, c0);
    check_load(w, c0, 1);
    repeat (10) tick();
    total++;
    if (rv_cnt != rv0) begin bad++; $display("FAIL collision_no_result got pulses=%0d want 0", rv_cnt - rv0); end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] w[$];
    int c0, n;
    bit found;
    wq.delete();
    load_start = 1;
    in_valid = 1;
    in_data = 16'($urandom);
    tick();
    load_start = 0;
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      if (!WE_n && wq.size() == 1) found = 1;
      else tick();
      n++;
    end
    total++;
    if (!found) begin bad++; $display("FAIL mid_write_timeout got writes=%0d want second WRITE", wq.size()); end
    rst = 0;
    @(negedge clk);
    total++;
    if (WE_n !== 1'b1 || addr !== 20'h0 || start !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_write_reset got WE_n=%b addr=%h start=%b busy=%b want 1/0/0/0", WE_n, addr, start, busy);
    end
    rst = 1;
    in_valid = 0;
    tick();
    for (int i = 0; i < LW; i++) w.push_back(16'($urandom));
    do_load(w, 0, 0, c0);
    check_load(w, c0, 1);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
    test_reset();
    test_stream(1);
    test_stream(0);
    test_gapped();
    test_result(16'h0123, 16'h0F45);
    test_result(16'($urandom), 16'($urandom));
    test_collision();
    test_reset_mid_write();
    test_result(16'($urandom), 16'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
